rnn_mem_responder: RTL and testbench

Memory-and-input responder sitting on the far side of the RNN core's memory/input bus. Holds weight, bias, step-count and input-vector banks preloaded by the host, answers the core's `mce`/`msel`/`maddr` read requests with one-cycle registered latency, captures the core's hidden-state writes into an output bank, and streams 32-bit input words on `i_en`. Also generates the `ready` start pulse and reports completion and protocol errors back to the host.

---
 rtl/rnn_mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_rnn_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_mem_responder.sv
// Far-side memory/input responder for the RNN core: host-preloaded weight,
// bias, step-count and input banks, a capture bank for hidden-state writes,
// and the run handshake (ready/busy/done) with a sticky protocol error flag.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | host may preload; start launches a run
// ARM    | run accepted; ready is raised on the following cycle
// WAIT   | ready pulse seen by core, waiting for busy to rise
// RUN    | core running; input stream advances on i_en
// DONE   | busy dropped; done pulse out, back to IDLE
module rnn_mem_responder #(
  parameter int T_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ld_en,
  input  logic [2:0]  ld_sel,
  input  logic [16:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic [16:0] rd_addr,
  output logic [19:0] rd_data,
  output logic        ready,
  input  logic        busy,
  input  logic        mce,
  input  logic [2:0]  msel,
  input  logic [16:0] maddr,
  input  logic [19:0] mdata_w,
  output logic [19:0] mdata_r,
  input  logic        i_en,
  output logic [31:0] idata,
  output logic        done,
  output logic        err,
  output logic [16:0] wr_count
);

  localparam int OUT_DEPTH = T_MAX * 64;
  localparam int OUT_AW    = $clog2(OUT_DEPTH);
  localparam int IN_AW     = $clog2(T_MAX);
  localparam int PTR_W     = IN_AW + 1;

  localparam logic [16:0]      OUT_LIM = 17'(OUT_DEPTH);
  localparam logic [16:0]      IN_LIM  = 17'(T_MAX);
  localparam logic [PTR_W-1:0] PTR_END = PTR_W'(T_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [19:0] w_ih_mem [2048];
  logic [19:0] b_ih_mem [64];
  logic [19:0] w_hh_mem [4096];
  logic [19:0] b_hh_mem [64];
  logic [19:0] step_cnt;
  logic [31:0] in_mem   [T_MAX];
  logic [19:0] out_mem  [OUT_DEPTH];

  logic [PTR_W-1:0] ptr_q;

  logic        ld_valid, ld_we, ld_err;
  logic [19:0] mdata_d;
  logic        core_err, out_we;
  logic        run_i_en, ptr_adv, ien_err;
  logic        start_run;

  assign start_run = (state_q == S_IDLE) && start;
  assign run_i_en  = (state_q == S_RUN) && i_en;
  assign ptr_adv   = run_i_en && (ptr_q < PTR_END);
  assign ien_err   = run_i_en && !(ptr_q < PTR_END);

  assign idata = (ptr_q < PTR_END) ? in_mem[ptr_q[IN_AW-1:0]] : 32'd0;

  // Preload target decode: which bank, and whether the address fits it.
  always_comb begin
    ld_valid = 1'b0;
    case (ld_sel)
      3'd0:    ld_valid = ld_addr < 17'd2048;
      3'd1:    ld_valid = ld_addr < 17'd64;
      3'd2:    ld_valid = ld_addr < 17'd4096;
      3'd3:    ld_valid = ld_addr < 17'd64;
      3'd4:    ld_valid = ld_addr == 17'd0;
      3'd6:    ld_valid = ld_addr < IN_LIM;
      default: ld_valid = 1'b0;
    endcase
    ld_we  = ld_en && (state_q == S_IDLE) && ld_valid && !reset;
    ld_err = ld_en && !((state_q == S_IDLE) && ld_valid);
  end

  // Core bus decode: read data to register next edge, write enable, errors.
  always_comb begin
    mdata_d  = '0;
    core_err = 1'b0;
    out_we   = 1'b0;
    if (mce) begin
      case (msel)
        3'd0: if (maddr < 17'd2048) mdata_d = w_ih_mem[maddr[10:0]];
              else core_err = 1'b1;
        3'd1: if (maddr < 17'd64) mdata_d = b_ih_mem[maddr[5:0]];
              else core_err = 1'b1;
        3'd2: if (maddr < 17'd4096) mdata_d = w_hh_mem[maddr[11:0]];
              else core_err = 1'b1;
        3'd3: if (maddr < 17'd64) mdata_d = b_hh_mem[maddr[5:0]];
              else core_err = 1'b1;
        3'd4: if (maddr == 17'd0) mdata_d = step_cnt;
        3'd5: if (maddr < OUT_LIM) out_we = 1'b1;
              else core_err = 1'b1;
        default: core_err = 1'b1;
      endcase
    end
  end

  // Host preload into the parameter and input banks (banks are never reset).
  always_ff @(posedge clk) begin
    if (ld_we) begin
      case (ld_sel)
        3'd0:    w_ih_mem[ld_addr[10:0]] <= ld_data[19:0];
        3'd1:    b_ih_mem[ld_addr[5:0]]  <= ld_data[19:0];
        3'd2:    w_hh_mem[ld_addr[11:0]] <= ld_data[19:0];
        3'd3:    b_hh_mem[ld_addr[5:0]]  <= ld_data[19:0];
        3'd4:    step_cnt                <= ld_data[19:0];
        3'd6:    in_mem[ld_addr[IN_AW-1:0]] <= ld_data;
        default: ;
      endcase
    end
  end

  // Hidden-state capture from the core.
  always_ff @(posedge clk) begin
    if (out_we && !reset) out_mem[maddr[OUT_AW-1:0]] <= mdata_w;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Run sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM:  state_d = S_WAIT;
      S_WAIT: if (busy) state_d = S_RUN;
      S_RUN:  if (!busy) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered handshake outputs, bus responses, counters and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_count <= '0;
      mdata_r  <= '0;
      rd_data  <= '0;
      ptr_q    <= '0;
    end else begin
      ready   <= (state_q == S_ARM);
      done    <= (state_q == S_RUN) && !busy;
      err     <= err | ld_err | core_err | ien_err;
      if (mce) mdata_r <= mdata_d;
      rd_data <= (rd_addr < OUT_LIM) ? out_mem[rd_addr[OUT_AW-1:0]] : 20'd0;
      if (start_run)    ptr_q <= '0;
      else if (ptr_adv) ptr_q <= ptr_q + 1'b1;
      // a run start in the same cycle as a write still leaves the count at zero
      if (start_run)   wr_count <= '0;
      else if (out_we) wr_count <= wr_count + 17'd1;
    end
  end

endmodule

// File: tb/tb_rnn_mem_responder.sv
// Bench for rnn_mem_responder: a bank/run model checked every cycle plus
// directed literal expectations from the scenarios of the block description.
module tb_rnn_mem_responder;

  logic        clk = 1'b0;
  logic        reset, start, ld_en, busy, mce, i_en;
  logic [2:0]  ld_sel, msel;
  logic [16:0] ld_addr, rd_addr, maddr;
  logic [31:0] ld_data;
  logic [19:0] mdata_w;
  logic [19:0] rd_data, mdata_r;
  logic        ready, done, err;
  logic [31:0] idata;
  logic [16:0] wr_count;

  int checks = 0;
  int failures = 0;

  rnn_mem_responder #(.T_MAX(64)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_en(ld_en), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .ready(ready), .busy(busy), .mce(mce), .msel(msel), .maddr(maddr),
    .mdata_w(mdata_w), .mdata_r(mdata_r), .i_en(i_en), .idata(idata),
    .done(done), .err(err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [19:0] m_wih [2048]; bit v_wih [2048];
  logic [19:0] m_bih [64];   bit v_bih [64];
  logic [19:0] m_whh [4096]; bit v_whh [4096];
  logic [19:0] m_bhh [64];   bit v_bhh [64];
  logic [19:0] m_step;       bit v_step = 0;
  logic [31:0] m_in  [64];   bit v_in  [64];
  logic [19:0] m_out [4096]; bit v_out [4096];

  bit          model_live = 0;
  int          phase;      // 0 idle, 1 start taken, 2 ready shown, 3 core busy, 4 finishing
  logic        m_ready, m_done, m_err;
  logic [16:0] m_wrc;
  logic [19:0] m_mr, m_rd;
  bit          m_mr_k, m_rd_k;
  logic [6:0]  m_ptr;

  always @(posedge clk) begin
    bit e;
    int old;
    if (reset) begin
      model_live = 1; phase = 0; m_ready = 0; m_done = 0; m_err = 0;
      m_wrc = '0; m_mr = '0; m_mr_k = 1; m_rd = '0; m_rd_k = 1; m_ptr = '0;
    end else if (model_live) begin
      e = 0;
      old = phase;
      if (rd_addr < 17'd4096) begin m_rd = m_out[rd_addr[11:0]]; m_rd_k = v_out[rd_addr[11:0]]; end
      else begin m_rd = '0; m_rd_k = 1; end
      if (mce) begin
        m_mr = '0; m_mr_k = 1;
        case (msel)
          3'd0: if (maddr < 17'd2048) begin m_mr = m_wih[maddr[10:0]]; m_mr_k = v_wih[maddr[10:0]]; end else e = 1;
          3'd1: if (maddr < 17'd64) begin m_mr = m_bih[maddr[5:0]]; m_mr_k = v_bih[maddr[5:0]]; end else e = 1;
          3'd2: if (maddr < 17'd4096) begin m_mr = m_whh[maddr[11:0]]; m_mr_k = v_whh[maddr[11:0]]; end else e = 1;
          3'd3: if (maddr < 17'd64) begin m_mr = m_bhh[maddr[5:0]]; m_mr_k = v_bhh[maddr[5:0]]; end else e = 1;
          3'd4: if (maddr == 17'd0) begin m_mr = m_step; m_mr_k = v_step; end
          3'd5: if (maddr < 17'd4096) begin
                  m_out[maddr[11:0]] = mdata_w; v_out[maddr[11:0]] = 1; m_wrc = m_wrc + 17'd1;
                end else e = 1;
          default: e = 1;
        endcase
      end
      if (ld_en) begin
        if (old != 0) e = 1;
        else case (ld_sel)
          3'd0: if (ld_addr < 17'd2048) begin m_wih[ld_addr[10:0]] = ld_data[19:0]; v_wih[ld_addr[10:0]] = 1; end else e = 1;
          3'd1: if (ld_addr < 17'd64) begin m_bih[ld_addr[5:0]] = ld_data[19:0]; v_bih[ld_addr[5:0]] = 1; end else e = 1;
          3'd2: if (ld_addr < 17'd4096) begin m_whh[ld_addr[11:0]] = ld_data[19:0]; v_whh[ld_addr[11:0]] = 1; end else e = 1;
          3'd3: if (ld_addr < 17'd64) begin m_bhh[ld_addr[5:0]] = ld_data[19:0]; v_bhh[ld_addr[5:0]] = 1; end else e = 1;
          3'd4: if (ld_addr == 17'd0) begin m_step = ld_data[19:0]; v_step = 1; end else e = 1;
          3'd6: if (ld_addr < 17'd64) begin m_in[ld_addr[5:0]] = ld_data; v_in[ld_addr[5:0]] = 1; end else e = 1;
          default: e = 1;
        endcase
      end
      if (old == 3 && i_en) begin
        if (m_ptr < 7'd64) m_ptr = m_ptr + 7'd1;
        else e = 1;
      end
      m_ready = (old == 1);
      m_done  = (old == 3) && !busy;
      case (old)
        0: if (start) begin phase = 1; m_ptr = '0; m_wrc = '0; end
        1: phase = 2;
        2: if (busy) phase = 3;
        3: if (!busy) phase = 4;
        default: phase = 0;
      endcase
      m_err = m_err | e;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("ready", 32'(ready), 32'(m_ready));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("wr_count", 32'(wr_count), 32'(m_wrc));
      if (m_mr_k) chk("mdata_r", 32'(mdata_r), 32'(m_mr));
      if (m_rd_k) chk("rd_data", 32'(rd_data), 32'(m_rd));
      if (m_ptr >= 7'd64) chk("idata_end", idata, 32'd0);
      else if (v_in[m_ptr[5:0]]) chk("idata", idata, m_in[m_ptr[5:0]]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] s, input logic [16:0] a, input logic [31:0] d);
    ld_en = 1; ld_sel = s; ld_addr = a; ld_data = d;
    tick();
    ld_en = 0;
  endtask

  task automatic core_rd(input logic [2:0] s, input logic [16:0] a);
    mce = 1; msel = s; maddr = a;
    tick();
    mce = 0;
  endtask

  initial begin
    reset = 1; start = 0; ld_en = 0; ld_sel = '0; ld_addr = '0; ld_data = '0;
    rd_addr = '0; busy = 0; mce = 0; msel = '0; maddr = '0; mdata_w = '0; i_en = 0;
    tick(); tick();
    reset = 0;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_mdata_r", 32'(mdata_r), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);

    load(3'd2, 17'h147, 32'h0001_2345);
    load(3'd1, 17'd5, 32'h0000_ABCD);
    load(3'd4, 17'd0, 32'h0000_0003);
    load(3'd0, 17'h2A, 32'h0005_5555);
    load(3'd6, 17'd0, 32'hA5A5_A5A5);
    load(3'd6, 17'd1, 32'h0000_FFFF);

    // back-to-back reads, one-cycle latency
    mce = 1; msel = 3'd2; maddr = 17'h147; tick();
    chk("rd_whh", 32'(mdata_r), 32'h12345);
    msel = 3'd1; maddr = 17'd5; tick();
    chk("rd_bih", 32'(mdata_r), 32'h0ABCD);
    msel = 3'd4; maddr = 17'd0; tick();
    chk("rd_step", 32'(mdata_r), 32'h3);
    maddr = 17'd1; tick();
    chk("rd_step_a1", 32'(mdata_r), 32'h0);
    msel = 3'd0; maddr = 17'h2A; tick();
    mce = 0; tick();
    chk("rd_hold", 32'(mdata_r), 32'h55555);
    chk("err_clean", 32'(err), 32'd0);

    // run 1
    start = 1; tick(); start = 0;
    chk("ready_early", 32'(ready), 32'd0);
    tick();
    chk("ready_pulse", 32'(ready), 32'd1);
    busy = 1; tick();
    chk("ready_fall", 32'(ready), 32'd0);
    i_en = 1;
    chk("idata_w0", idata, 32'hA5A5_A5A5);
    tick();
    chk("idata_w1", idata, 32'h0000_FFFF);
    tick(); i_en = 0;
    mce = 1; msel = 3'd5; maddr = 17'h89; mdata_w = 20'hF0000; tick(); mce = 0;
    chk("wr_count1", 32'(wr_count), 32'd1);
    chk("wr_mdata_r", 32'(mdata_r), 32'd0);
    rd_addr = 17'h89; tick();
    chk("readback", 32'(rd_data), 32'hF0000);
    mce = 1; msel = 3'd5; maddr = 17'h89; mdata_w = 20'h11111; tick(); mce = 0;
    chk("readback_old", 32'(rd_data), 32'hF0000);
    tick();
    chk("readback_new", 32'(rd_data), 32'h11111);
    start = 1; tick(); start = 0;
    tick(); tick();
    busy = 0; tick();
    chk("done_pulse", 32'(done), 32'd1);
    tick();
    chk("done_fall", 32'(done), 32'd0);
    chk("no_rearm", 32'(ready), 32'd0);
    tick();

    // run 2: exhaust input stream, then reset mid-run
    start = 1; tick(); start = 0;
    chk("wr_count_clr", 32'(wr_count), 32'd0);
    tick();
    busy = 1; tick();
    i_en = 1;
    for (int i = 0; i < 64; i++) tick();
    i_en = 0;
    chk("idata_exh", idata, 32'd0);
    chk("err_before_over", 32'(err), 32'd0);
    i_en = 1; tick(); i_en = 0;
    chk("err_over", 32'(err), 32'd1);
    reset = 1; tick(); reset = 0; busy = 0;
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_wrc", 32'(wr_count), 32'd0);
    chk("mid_rst_idata", idata, 32'hA5A5_A5A5);
    tick(); tick();
    chk("idle_no_ready", 32'(ready), 32'd0);
    core_rd(3'd0, 17'h2A);
    chk("wih_kept", 32'(mdata_r), 32'h55555);
    mce = 1; msel = 3'd7; maddr = 17'd0; tick(); mce = 0;
    chk("bad_msel_err", 32'(err), 32'd1);
    chk("bad_msel_data", 32'(mdata_r), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
